controlador_edicion_rtc: RTL and testbench

Edit-mode controller for the RTC time/date field counters. It turns debounced push-button levels into the field-select code `en_count` and single-cycle `enUP`/`enDOWN` step pulses, with hold-to-auto-repeat. It also issues a commit strobe when the user leaves edit mode. It sits between the button debouncers and the bank of per-field 2-digit counters (seconds … day … year), which qualify on `en_count` and step on the pulses.

---
 rtl/controlador_edicion_rtc.sv | 192 +++++++++++++++++++
 tb/tb_controlador_edicion_rtc.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/controlador_edicion_rtc.sv
// controlador_edicion_rtc
// Edit-mode controller for the RTC field counters. Turns debounced button
// levels into a field-select code and single-cycle up/down step pulses.
// Holding a step button auto-repeats the pulse. Leaving edit mode emits a
// one-cycle commit strobe.
//
// Ports:
//   clk          system clock
//   reset        synchronous, active-high reset
//   btn_prog     rising edge toggles edit mode
//   btn_left     rising edge selects the previous field
//   btn_right    rising edge selects the next field
//   btn_up       increment, auto-repeats while held
//   btn_down     decrement, auto-repeats while held
//   en_count     selected field code (1..NUM_FIELDS), 0 outside edit mode
//   enUP         one-cycle increment pulse
//   enDOWN       one-cycle decrement pulse
//   edit_mode    high while editing
//   write_strobe one-cycle pulse when an edit session ends
//
// state    | meaning
// ---------+-----------------------------------------------------------
// S_IDLE   | not editing, waiting for a prog edge
// S_EDIT   | editing, field navigation and step edges accepted
// S_HOLD   | step button held, waiting REPEAT_DELAY for first repeat
// S_REPEAT | step button still held, pulsing every REPEAT_PERIOD
// S_COMMIT | single cycle that emits write_strobe before going idle

module controlador_edicion_rtc #(
    parameter int NUM_FIELDS    = 9,
    parameter int REPEAT_DELAY  = 50_000_000,
    parameter int REPEAT_PERIOD = 26_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_prog,
    input  logic       btn_left,
    input  logic       btn_right,
    input  logic       btn_up,
    input  logic       btn_down,
    output logic [3:0] en_count,
    output logic       enUP,
    output logic       enDOWN,
    output logic       edit_mode,
    output logic       write_strobe
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_EDIT   = 3'd1,
        S_HOLD   = 3'd2,
        S_REPEAT = 3'd3,
        S_COMMIT = 3'd4
    } state_t;

    localparam logic [26:0] DELAY_TC   = 27'(REPEAT_DELAY - 1);
    localparam logic [26:0] PERIOD_TC  = 27'(REPEAT_PERIOD - 1);
    localparam logic [3:0]  LAST_FIELD = 4'(NUM_FIELDS);

    state_t      state, state_d;
    logic [26:0] cnt, cnt_d;
    logic        dir_up, dir_up_d;
    logic        step_up, step_dn;

    logic [4:0]  btn, btn_prev, btn_edge;
    logic        prog_edge, left_edge, right_edge, up_edge, down_edge;

    logic [3:0]  en_count_d;
    logic        enUP_d, enDOWN_d, edit_mode_d, write_strobe_d;

    logic        held, opposite;
    logic [26:0] term_count;

    assign btn        = {btn_prog, btn_left, btn_right, btn_up, btn_down};
    assign btn_edge   = btn & ~btn_prev;
    assign prog_edge  = btn_edge[4];
    assign left_edge  = btn_edge[3];
    assign right_edge = btn_edge[2];
    assign up_edge    = btn_edge[1];
    assign down_edge  = btn_edge[0];

    // State, timer, edge history and registered outputs.
    // Prev registers reset to 1 so a button held through reset yields no edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state        <= S_IDLE;
            cnt          <= '0;
            dir_up       <= 1'b0;
            btn_prev     <= '1;
            en_count     <= '0;
            enUP         <= 1'b0;
            enDOWN       <= 1'b0;
            edit_mode    <= 1'b0;
            write_strobe <= 1'b0;
        end else begin
            state        <= state_d;
            cnt          <= cnt_d;
            dir_up       <= dir_up_d;
            btn_prev     <= btn;
            en_count     <= en_count_d;
            enUP         <= enUP_d;
            enDOWN       <= enDOWN_d;
            edit_mode    <= edit_mode_d;
            write_strobe <= write_strobe_d;
        end
    end

    assign held       = dir_up ? btn_up   : btn_down;
    assign opposite   = dir_up ? btn_down : btn_up;
    assign term_count = (state == S_HOLD) ? DELAY_TC : PERIOD_TC;

    // Next state, repeat timer and step events.
    always_comb begin
        state_d  = state;
        cnt_d    = cnt;
        dir_up_d = dir_up;
        step_up  = 1'b0;
        step_dn  = 1'b0;
        case (state)
            S_IDLE: begin
                if (prog_edge) begin
                    state_d = S_EDIT;
                    cnt_d   = '0;
                end
            end
            S_EDIT: begin
                if (prog_edge) begin
                    state_d = S_COMMIT;
                    cnt_d   = '0;
                end else if (up_edge && !btn_down) begin
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                    dir_up_d = 1'b1;
                    step_up  = 1'b1;
                end else if (down_edge && !btn_up) begin
                    state_d  = S_HOLD;
                    cnt_d    = '0;
                    dir_up_d = 1'b0;
                    step_dn  = 1'b1;
                end
            end
            S_HOLD, S_REPEAT: begin
                if (prog_edge) begin
                    state_d = S_COMMIT;
                    cnt_d   = '0;
                end else if (!held || opposite) begin
                    state_d = S_EDIT;
                    cnt_d   = '0;
                end else if (cnt == term_count) begin
                    state_d = S_REPEAT;
                    cnt_d   = '0;
                    step_up = dir_up;
                    step_dn = !dir_up;
                end else begin
                    cnt_d = cnt + 27'd1;
                end
            end
            S_COMMIT: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Output values registered on the same edge as the state change.
    always_comb begin
        en_count_d     = en_count;
        enUP_d         = step_up;
        enDOWN_d       = step_dn;
        edit_mode_d    = (state_d == S_EDIT) || (state_d == S_HOLD) ||
                         (state_d == S_REPEAT);
        write_strobe_d = (state_d == S_COMMIT);
        if ((state_d == S_IDLE) || (state_d == S_COMMIT)) begin
            en_count_d = '0;
        end else if (state == S_IDLE) begin
            en_count_d = 4'd1;
        end else if ((state == S_EDIT) && (state_d == S_EDIT)) begin
            // Staying in EDIT means no step pulse was issued this cycle,
            // so navigation applies; simultaneous left+right cancel out.
            if (right_edge && !left_edge) begin
                en_count_d = (en_count == LAST_FIELD) ? 4'd1 : en_count + 4'd1;
            end else if (left_edge && !right_edge) begin
                en_count_d = (en_count == 4'd1) ? LAST_FIELD : en_count - 4'd1;
            end
        end
    end

endmodule

// File: tb/tb_controlador_edicion_rtc.sv
module tb_controlador_edicion_rtc;

    localparam int NF = 9;
    localparam int RD = 8;
    localparam int RP = 4;

    // Button vector layout: {prog, left, right, up, down}
    localparam logic [4:0] BP = 5'b10000;
    localparam logic [4:0] BL = 5'b01000;
    localparam logic [4:0] BR = 5'b00100;
    localparam logic [4:0] BU = 5'b00010;
    localparam logic [4:0] BD = 5'b00001;
    localparam logic [4:0] BN = 5'b00000;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       btn_prog = 1'b0, btn_left = 1'b0, btn_right = 1'b0;
    logic       btn_up = 1'b0, btn_down = 1'b0;
    logic [3:0] en_count;
    logic       enUP, enDOWN, edit_mode, write_strobe;

    always #5 clk = ~clk;

    controlador_edicion_rtc #(
        .NUM_FIELDS   (NF),
        .REPEAT_DELAY (RD),
        .REPEAT_PERIOD(RP)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .btn_prog    (btn_prog),
        .btn_left    (btn_left),
        .btn_right   (btn_right),
        .btn_up      (btn_up),
        .btn_down    (btn_down),
        .en_count    (en_count),
        .enUP        (enUP),
        .enDOWN      (enDOWN),
        .edit_mode   (edit_mode),
        .write_strobe(write_strobe)
    );

    typedef struct packed {
        logic [3:0] en;
        logic       up;
        logic       dn;
        logic       em;
        logic       ws;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: session flags, selected field, held direction and
    // the absolute cycle at which the next auto-repeat pulse is due.
    bit         m_edit = 0;
    bit         m_commit = 0;
    int         m_field = 0;
    int         m_dir = 0;           // 0 none, 1 up, 2 down
    longint     m_cycle = 0;
    longint     m_next = 0;
    logic [4:0] m_prev = '1;

    task automatic apply(input logic r, input logic [4:0] b);
        exp_t       e;
        logic [4:0] ed;
        logic       held, opp;
        @(negedge clk);
        reset = r;
        {btn_prog, btn_left, btn_right, btn_up, btn_down} = b;
        e = '0;
        if (r) begin
            m_edit   = 0;
            m_commit = 0;
            m_dir    = 0;
            m_prev   = '1;
        end else begin
            ed     = b & ~m_prev;
            m_prev = b;
            if (m_commit) begin
                m_commit = 0;
            end else if (!m_edit) begin
                if (ed[4]) begin
                    m_edit  = 1;
                    m_field = 1;
                end
            end else if (ed[4]) begin
                m_edit   = 0;
                m_commit = 1;
                m_dir    = 0;
                e.ws     = 1'b1;
            end else if (m_dir == 0) begin
                if (ed[1] && !b[0]) begin
                    e.up   = 1'b1;
                    m_dir  = 1;
                    m_next = m_cycle + RD;
                end else if (ed[0] && !b[1]) begin
                    e.dn   = 1'b1;
                    m_dir  = 2;
                    m_next = m_cycle + RD;
                end else if (ed[2] && !ed[3]) begin
                    m_field = (m_field == NF) ? 1 : m_field + 1;
                end else if (ed[3] && !ed[2]) begin
                    m_field = (m_field == 1) ? NF : m_field - 1;
                end
            end else begin
                held = (m_dir == 1) ? b[1] : b[0];
                opp  = (m_dir == 1) ? b[0] : b[1];
                if (!held || opp) begin
                    m_dir = 0;
                end else if (m_cycle == m_next) begin
                    if (m_dir == 1) e.up = 1'b1;
                    else e.dn = 1'b1;
                    m_next = m_cycle + RP;
                end
            end
        end
        e.em = m_edit;
        e.en = m_edit ? 4'(m_field) : 4'd0;
        m_cycle++;
        sb_q.push_back(e);
    endtask

    task automatic press(input logic [4:0] b);
        apply(1'b0, b);
        apply(1'b0, BN);
    endtask

    task automatic hold(input logic [4:0] b, input int n);
        repeat (n) apply(1'b0, b);
    endtask

    task automatic chk(input string nm, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", nm, $time, act, exp);
        end
    endtask

    // Monitor: compares each registered response just after the edge.
    always @(posedge clk) begin
        exp_t e;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            chk("en_count", en_count, e.en);
            chk("enUP", {3'b0, enUP}, {3'b0, e.up});
            chk("enDOWN", {3'b0, enDOWN}, {3'b0, e.dn});
            chk("edit_mode", {3'b0, edit_mode}, {3'b0, e.em});
            chk("write_strobe", {3'b0, write_strobe}, {3'b0, e.ws});
            chk("pulse_exclusive", {3'b0, enUP & enDOWN}, 4'd0);
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1);
    end

    initial begin
        logic [4:0] b;
        logic       r;

        repeat (3) apply(1'b1, BN);
        hold(BN, 2);

        // Field navigation and wrap
        press(BP);
        repeat (6) press(BR);
        press(BL);
        repeat (3) press(BR);
        press(BR);
        press(BL);
        press(BR);

        // Hold-to-repeat
        hold(BU, 20);
        hold(BN, 6);

        // Conflicting inputs
        apply(1'b0, BU | BD);
        hold(BN, 2);
        hold(BU, 3);
        hold(BU | BD, 6);
        hold(BN, 2);
        apply(1'b0, BL | BR);
        hold(BN, 2);

        // Commit from REPEAT, then idle buttons ignored
        hold(BU, 12);
        apply(1'b0, BU | BP);
        apply(1'b0, BU);
        hold(BN, 2);
        press(BU);
        press(BL);

        // Reset behaviour
        repeat (3) apply(1'b1, BP);
        hold(BP, 4);
        hold(BN, 2);
        press(BP);
        repeat (4) press(BR);
        hold(BU, 3);
        apply(1'b1, BU);
        hold(BN, 3);

        // Randomized button activity
        b = BN;
        for (int i = 0; i < 3000; i++) begin
            for (int k = 0; k < 4; k++) begin
                if ($urandom_range(7) == 0) b[k] = ~b[k];
            end
            if ($urandom_range(29) == 0) b[4] = ~b[4];
            r = ($urandom_range(399) == 0);
            apply(r, b);
        end

        hold(BN, 3);
        @(posedge clk);
        #2;
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", sb_q.size());
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
